cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 tb/tb_cdb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per result source, one registered broadcast per cycle.
// Define CDB_ARB_RR_EN for round-robin arbitration; the default build is fixed priority (source 0 highest).
module cdb_arbiter #(
    parameter int NSRC = 3,
    parameter int TAGW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic [NSRC-1:0]      req_valid,
    input  logic [32*NSRC-1:0]   req_value,
    input  logic [TAGW*NSRC-1:0] req_tag,
    output logic [NSRC-1:0]      req_ready,
    output logic                 cdb_valid,
    output logic [31:0]          cdb_value,
    output logic [TAGW-1:0]      cdb_tag
);

    // Handshake: a result moves into hold[i] on any rising edge where req_valid[i] and
    // req_ready[i] are both high; req_ready is combinational and may drop without notice.

    logic [NSRC-1:0] hold_v;
    logic [31:0]     hold_val [NSRC];
    logic [TAGW-1:0] hold_tag [NSRC];
    logic [NSRC-1:0] grant;
    logic [31:0]     gnt_val;
    logic [TAGW-1:0] gnt_tag;
    logic            active;

    assign active = rdy & ~flush & ~rst;

`ifdef CDB_ARB_RR_EN
    localparam int PTRW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [PTRW-1:0] ptr;
    logic [PTRW-1:0] gnt_idx;

    // Search begins one past the last winner and wraps around.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int k = 1; k <= NSRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (active && hold_v[idx] && grant == '0) grant[idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) gnt_idx = PTRW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr <= PTRW'(NSRC - 1);
        end else if (rdy && grant != '0) begin
            ptr <= gnt_idx;
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (active && hold_v[i] && grant == '0) grant[i] = 1'b1;
        end
    end
`endif

    // Grant is one-hot, so an OR-reduction acts as the winner mux.
    always_comb begin
        gnt_val = '0;
        gnt_tag = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                gnt_val = gnt_val | hold_val[i];
                gnt_tag = gnt_tag | hold_tag[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            req_ready[i] = active & (~hold_v[i] | grant[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v    <= '0;
            cdb_valid <= 1'b0;
            cdb_value <= '0;
            cdb_tag   <= '0;
        end else if (flush) begin
            hold_v    <= '0;
            cdb_valid <= 1'b0;
        end else if (rdy) begin
            cdb_valid <= |grant;
            if (|grant) begin
                cdb_value <= gnt_val;
                cdb_tag   <= gnt_tag;
            end
            // A same-edge refill of a granted entry wins over the clear.
            for (int i = 0; i < NSRC; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hold_v[i] <= 1'b1;
                end else if (grant[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

    // Payload is qualified by hold_v, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                hold_val[i] <= req_value[32*i +: 32];
                hold_tag[i] <= req_tag[TAGW*i +: TAGW];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter: a pending-result model predicts broadcasts into
// a queue that a separate monitor drains against the DUT's cdb outputs.
module tb_cdb_arbiter;

    localparam int NSRC = 3;
    localparam int TAGW = 4;
    localparam int EW   = TAGW + 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rdy = 1'b0;
    logic                 flush = 1'b0;
    logic [NSRC-1:0]      req_valid = '0;
    logic [32*NSRC-1:0]   req_value = '0;
    logic [TAGW*NSRC-1:0] req_tag = '0;
    logic [NSRC-1:0]      req_ready;
    logic                 cdb_valid;
    logic [31:0]          cdb_value;
    logic [TAGW-1:0]      cdb_tag;

    cdb_arbiter #(.NSRC(NSRC), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .req_valid(req_valid), .req_value(req_value), .req_tag(req_tag),
        .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_tag(cdb_tag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    // Reference model: which sources hold an undelivered result, and what the bus last showed.
    bit              m_pend [NSRC];
    logic [31:0]     m_val  [NSRC];
    logic [TAGW-1:0] m_tag  [NSRC];
    int              m_last_winner = NSRC - 1;
    bit              m_cdb_v = 1'b0;
    logic [31:0]     m_last_val = '0;
    logic [TAGW-1:0] m_last_tag = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_winner();
        int idx;
        for (int k = 0; k < NSRC; k++) begin
`ifdef CDB_ARB_RR_EN
            idx = (m_last_winner + 1 + k) % NSRC;
`else
            idx = k;
`endif
            if (m_pend[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock of stimulus: drive at negedge, check req_ready, then advance the model at posedge.
    task automatic step(input bit r, input bit rd, input bit fl, input logic [NSRC-1:0] v,
                        input logic [32*NSRC-1:0] val, input logic [TAGW*NSRC-1:0] tg);
        int w;
        logic [NSRC-1:0] exp_rdy;
        @(negedge clk);
        rst = r; rdy = rd; flush = fl; req_valid = v; req_value = val; req_tag = tg;
        #1;
        w = (rd && !fl && !r) ? pick_winner() : -1;
        for (int i = 0; i < NSRC; i++) exp_rdy[i] = rd && !fl && !r && (!m_pend[i] || w == i);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NSRC; i++) m_pend[i] = 1'b0;
            m_last_winner = NSRC - 1;
            m_cdb_v = 1'b0; m_last_val = '0; m_last_tag = '0;
        end else if (fl) begin
            for (int i = 0; i < NSRC; i++) m_pend[i] = 1'b0;
            m_last_winner = NSRC - 1;
            m_cdb_v = 1'b0;
        end else if (!rd) begin
            // Everything freezes, including a strobe that was already high.
            if (m_cdb_v) exp_q.push_back({m_last_tag, m_last_val});
        end else begin
            m_cdb_v = (w >= 0);
            if (w >= 0) begin
                exp_q.push_back({m_tag[w], m_val[w]});
                m_last_val = m_val[w]; m_last_tag = m_tag[w];
                m_pend[w] = 1'b0;
                m_last_winner = w;
            end
            for (int i = 0; i < NSRC; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    m_pend[i] = 1'b1;
                    m_val[i]  = val[32*i +: 32];
                    m_tag[i]  = tg[TAGW*i +: TAGW];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, '0, '0, '0);
    endtask

    // Monitor: every broadcast must be the oldest predicted one; silence is legal only when none is due.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            check("cdb_valid", 64'(cdb_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (cdb_valid === 1'b1) check("cdb_bcast", 64'({cdb_tag, cdb_value}), 64'(e));
            end
            check("cdb_data", 64'({cdb_tag, cdb_value}), 64'({m_last_tag, m_last_val}));
        end
    end

    initial begin
        logic [32*NSRC-1:0] rv;
        logic [TAGW*NSRC-1:0] rt;
        bit r, fl, rd;

        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, '0, '0, '0);

        // Single ALU result, value 0xAA tag 5.
        idle(1);
        step(1'b0, 1'b1, 1'b0, 3'b001, 96'h0AA, 12'h005);
        idle(3);

        // All three sources at once, tags 1/2/3.
        step(1'b1, 1'b1, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 3'b111, {32'h33, 32'h22, 32'h11}, {4'd3, 4'd2, 4'd1});
        idle(4);

        // Source 2 pending while source 0 streams a new result every cycle.
        step(1'b0, 1'b1, 1'b0, 3'b100, {32'h99, 64'h0}, {4'd9, 8'h0});
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b1, 1'b0, 3'b001, {64'h0, 32'h100 + 32'(k)}, {8'h0, 4'(k)});
        idle(4);

        // Pause with two entries pending.
        step(1'b0, 1'b1, 1'b0, 3'b011, {32'h0, 32'hB2, 32'hB1}, {4'd0, 4'd12, 4'd11});
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 3'b111, '1, '1);
        idle(4);

        // Flush with three entries pending; their tags must never appear.
        step(1'b0, 1'b1, 1'b0, 3'b111, {32'hC3, 32'hC2, 32'hC1}, {4'd15, 4'd14, 4'd13});
        step(1'b0, 1'b1, 1'b1, 3'b111, '1, '1);
        idle(4);

        // Reset in the middle of a sustained burst.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 3'b111,
                                         {$urandom, $urandom, $urandom}, 12'($urandom));
        step(1'b1, 1'b1, 1'b0, 3'b111, '1, '1);
        step(1'b0, 1'b1, 1'b0, 3'b111, {32'hD3, 32'hD2, 32'hD1}, {4'd3, 4'd2, 4'd1});
        idle(4);

        // Random traffic with occasional pause, flush and reset.
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 99) == 0);
            fl = ($urandom_range(0, 29) == 0);
            rd = ($urandom_range(0, 7) != 0);
            rv = {$urandom, $urandom, $urandom};
            rt = 12'($urandom);
            step(r, rd, fl, 3'($urandom_range(0, 7)), rv, rt);
        end
        idle(6);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
